csr_mmio_router: RTL and testbench
==================================

# csr_mmio_router

Fans the AFU's single CCI-P MMIO request stream (c0 rx MMIO read/write) out to NUM_SUB sub-CSR blocks over `sub_csr_if`-typed buses, and merges their read responses back into the single CCI-P c2 MMIO response channel. It sits between the AFU top-level CCI-P port and the per-function CSR blocks, on the `to_sub` side of every `sub_csr_if`. It also answers reads to unmapped addresses itself, so every host read gets exactly one response.

## Interface
Parameters:
- NUM_SUB, 4: number of sub-CSR ports, 1..8.
- BASE_ADDR, 16'h0000: first MMIO address (32-bit word units) routed to sub 0.
- SUB_ADDR_BITS, 10: log2 of the address window per sub, in words; 4 KB per sub by default.
- RSP_DEPTH, 4: depth of each per-requester response FIFO, power of 2, at least 2.
- DEFAULT_RDATA, 64'h0: read data returned for unmapped reads.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_hdr  in  t_ccip_c0_ReqMmioHdr  MMIO request header: address[15:0], length[1:0], tid[8:0].
- in_data  in  t_ccip_mmioData (64)  write data.
- in_rdValid  in  1  MMIO read request strobe.
- in_wrValid  in  1  MMIO write request strobe.
- sub_rx  out  NUM_SUB × t_sub_csr_rx  per-sub request bus.
- sub_tx  in  NUM_SUB × t_sub_csr_tx  per-sub response bus.
- out_mmioRdValid  out  1  c2 MMIO read response strobe.
- out_hdr  out  t_ccip_c2_RspMmioHdr  response header; tid only.
- out_data  out  64  response data.
- err_overflow  out  NUM_SUB+1  sticky flag per response FIFO; bit NUM_SUB is the internal default responder.

## Operation
- **Request stage.** in_hdr, in_data, in_rdValid and in_wrValid are registered once. The registered request is decoded:
  - off = address − BASE_ADDR, as a 16-bit unsigned subtraction.
  - idx = off >> SUB_ADDR_BITS.
  - hit = (address ≥ BASE_ADDR) && (idx < NUM_SUB).
- **Hit.** sub_rx[idx] carries the registered hdr and data, and the rdValid/wrValid strobes for exactly one cycle. The address is passed unmodified; the sub decodes its own offset. All other subs see both strobes at 0. hdr/data are broadcast to all subs; only the strobes are gated.
- **Miss write.** Dropped silently.
- **Miss read.** Pushes {tid, DEFAULT_RDATA} into the internal responder FIFO (requester NUM_SUB).
- **Both strobes set.** If rdValid and wrValid are both set, both are forwarded or handled independently, as above.
- **Response capture.** Each sub_tx[i].mmioRdValid pulse pushes {hdr.tid, data} into FIFO i.
  - A push into a full FIFO is dropped and sets err_overflow[i].
  - err_overflow bits clear only on reset.
- **Arbitration.** Round-robin over the NUM_SUB+1 FIFOs. The pointer resets to 0.
  - Each cycle, grant the first non-empty FIFO at or after the pointer, wrapping modulo NUM_SUB+1.
  - Pop the granted FIFO and load the output register.
  - Set pointer = grant+1, wrapped.
  - If no FIFO is non-empty, the pointer is unchanged.
  - At most one response per cycle.
- **Output register.** out_mmioRdValid is 1 for exactly one cycle per pop. out_hdr.tid and out_data come from the popped entry. When not valid, out_hdr and out_data hold their last value.
- **Simultaneous events.** Push and pop on the same FIFO in the same cycle is legal at any occupancy, including full: the pop frees a slot, so no overflow. Pushes from all subs in one cycle are all accepted if not full.
- **Ordering.** Responses from the same FIFO leave in arrival order. No ordering is guaranteed across FIFOs; the host matches responses by tid.
- **Reset.** Reset mid-operation discards the request register and all FIFO contents. Pending host reads are lost; the host handles this via its timeout.

## Timing
- Reset values: sub_rx all fields 0, out_mmioRdValid 0, out_hdr 0, out_data 0, err_overflow 0, FIFOs empty, RR pointer 0.
- Request in cycle T: sub_rx strobe in cycle T+1.
- Miss read in cycle T: pushed at the end of T+1, out_mmioRdValid in T+3 if uncontended.
- Sub response strobe in cycle R: out_mmioRdValid in R+2 if uncontended.
- Worst-case extra wait under contention: NUM_SUB cycles per pending response ahead in RR order.
- Sustained throughput: one response per cycle.

## Test plan
- Write addr 16'h0405, data 64'hDEAD_BEEF at T -> sub_rx[1].wrValid=1 at T+1 with the same addr and data; all other subs' strobes 0; no c2 response.
- Read addr 16'h0010, tid 9'h05; sub 0 responds data 64'h1234 the cycle after it sees the request -> out_mmioRdValid with tid 5, data 64'h1234, exactly 2 cycles after the sub response.
- Read addr 16'h1000 with defaults (unmapped), tid 9'h1FF, at T -> no sub strobe; out at T+3 with tid 9'h1FF, data 64'h0.
- All 4 subs pulse a response in the same cycle, tids 1..4, pointer at 0 -> four consecutive out_mmioRdValid cycles with tids 1,2,3,4; pointer ends at 4.
- Sub 2 pulses 6 responses back-to-back while sub 0 is kept busy, RSP_DEPTH 4 -> err_overflow[2] asserts; the first responses are delivered in order; the bit stays set until rst_n is asserted, after which all outputs are 0.
- Assert rst_n low while 3 responses are queued -> out_mmioRdValid drops to 0 immediately (asynchronously); after release, no stale responses appear.

Source files
------------

// File: rtl/csr_mmio_router.sv
// MMIO request fan-out to NUM_SUB sub-CSR blocks, with round-robin merging of
// their read responses (plus defaults for unmapped reads) onto one c2 channel.
package csr_mmio_router_pkg;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef logic [63:0] t_ccip_mmioData;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_mmioData      data;
    logic                rdValid;
    logic                wrValid;
  } t_sub_csr_rx;

  typedef struct packed {
    logic                mmioRdValid;
    t_ccip_c2_RspMmioHdr hdr;
    t_ccip_mmioData      data;
  } t_sub_csr_tx;
endpackage

module csr_mmio_router
  import csr_mmio_router_pkg::*;
#(
  parameter int          NUM_SUB       = 4,
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int          SUB_ADDR_BITS = 10,
  parameter int          RSP_DEPTH     = 4,
  parameter logic [63:0] DEFAULT_RDATA = 64'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  t_ccip_c0_ReqMmioHdr       in_hdr,
  input  t_ccip_mmioData            in_data,
  input  logic                      in_rdValid,
  input  logic                      in_wrValid,
  output t_sub_csr_rx [NUM_SUB-1:0] sub_rx,
  input  t_sub_csr_tx [NUM_SUB-1:0] sub_tx,
  output logic                      out_mmioRdValid,
  output t_ccip_c2_RspMmioHdr       out_hdr,
  output t_ccip_mmioData            out_data,
  output logic [NUM_SUB:0]          err_overflow
);

  localparam int NREQ  = NUM_SUB + 1;
  localparam int SEL_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } t_entry;

  t_ccip_c0_ReqMmioHdr req_hdr;
  t_ccip_mmioData      req_data;
  logic                req_rd;
  logic                req_wr;

  logic [15:0]      off;
  logic [15:0]      idx_wide;
  logic             hit;
  logic [SEL_W-1:0] idx;

  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  accept;
  logic [NREQ-1:0]  pop;
  logic [NREQ-1:0]  nonempty;
  t_entry           push_entry [NREQ];

  t_entry           mem    [NREQ][RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NREQ];
  logic [PTR_W-1:0] rd_ptr [NREQ];
  logic [CNT_W-1:0] count  [NREQ];

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic [SEL_W:0]   cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_hdr  <= '0;
      req_data <= '0;
      req_rd   <= 1'b0;
      req_wr   <= 1'b0;
    end else begin
      req_hdr  <= in_hdr;
      req_data <= in_data;
      req_rd   <= in_rdValid;
      req_wr   <= in_wrValid;
    end
  end

  // Decode the registered address; the subtraction wraps, so below-base
  // addresses are excluded explicitly.
  always_comb begin
    off      = req_hdr.address - BASE_ADDR;
    idx_wide = off >> SUB_ADDR_BITS;
    hit      = (req_hdr.address >= BASE_ADDR) && (idx_wide < 16'(NUM_SUB));
    idx      = idx_wide[SEL_W-1:0];
  end

  always_comb begin
    for (int i = 0; i < NUM_SUB; i++) begin
      sub_rx[i].hdr     = req_hdr;
      sub_rx[i].data    = req_data;
      sub_rx[i].rdValid = req_rd && hit && (idx == SEL_W'(i));
      sub_rx[i].wrValid = req_wr && hit && (idx == SEL_W'(i));
    end
  end

  // Requester NUM_SUB is the internal responder for unmapped reads.
  always_comb begin
    for (int i = 0; i < NUM_SUB; i++) begin
      push[i]       = sub_tx[i].mmioRdValid;
      push_entry[i] = '{tid: sub_tx[i].hdr.tid, data: sub_tx[i].data};
    end
    push[NUM_SUB]       = req_rd && !hit;
    push_entry[NUM_SUB] = '{tid: req_hdr.tid, data: DEFAULT_RDATA};
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      nonempty[i] = (count[i] != '0);
    end
  end

  // First non-empty FIFO at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(NREQ)) cand = cand - (SEL_W+1)'(NREQ);
      if (!grant_valid && nonempty[cand[SEL_W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = cand[SEL_W-1:0];
      end
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO that is
  // also being popped is still accepted.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pop[i]    = grant_valid && (grant == SEL_W'(i));
      accept[i] = push[i] && ((count[i] != CNT_W'(RSP_DEPTH)) || pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= push_entry[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      err_overflow <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
        if (push[i] && !accept[i]) err_overflow[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mmioRdValid <= 1'b0;
      out_hdr         <= '0;
      out_data        <= '0;
      rr_ptr          <= '0;
    end else if (grant_valid) begin
      out_mmioRdValid <= 1'b1;
      out_hdr.tid     <= mem[grant][rd_ptr[grant]].tid;
      out_data        <= mem[grant][rd_ptr[grant]].data;
      rr_ptr          <= (grant == SEL_W'(NREQ-1)) ? '0 : grant + 1'b1;
    end else begin
      out_mmioRdValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_mmio_router.sv
// Self-checking bench for csr_mmio_router: decode vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_csr_mmio_router;
  import csr_mmio_router_pkg::*;

  localparam int          NUM_SUB       = 4;
  localparam logic [15:0] BASE_ADDR     = 16'h0000;
  localparam int          SUB_ADDR_BITS = 10;
  localparam int          RSP_DEPTH     = 4;
  localparam logic [63:0] DEFAULT_RDATA = 64'h0;
  localparam int          NREQ          = NUM_SUB + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  t_ccip_c0_ReqMmioHdr       in_hdr;
  t_ccip_mmioData            in_data;
  logic                      in_rdValid;
  logic                      in_wrValid;
  t_sub_csr_rx [NUM_SUB-1:0] sub_rx;
  t_sub_csr_tx [NUM_SUB-1:0] sub_tx;
  logic                      out_mmioRdValid;
  t_ccip_c2_RspMmioHdr       out_hdr;
  t_ccip_mmioData            out_data;
  logic [NUM_SUB:0]          err_overflow;

  csr_mmio_router #(
    .NUM_SUB(NUM_SUB), .BASE_ADDR(BASE_ADDR), .SUB_ADDR_BITS(SUB_ADDR_BITS),
    .RSP_DEPTH(RSP_DEPTH), .DEFAULT_RDATA(DEFAULT_RDATA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_hdr(in_hdr), .in_data(in_data),
    .in_rdValid(in_rdValid), .in_wrValid(in_wrValid), .sub_rx(sub_rx),
    .sub_tx(sub_tx), .out_mmioRdValid(out_mmioRdValid), .out_hdr(out_hdr),
    .out_data(out_data), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, a round-robin index, and the
  // request/output registers as plain variables.
  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  rsp_t                mq [NREQ][$];
  t_ccip_c0_ReqMmioHdr m_hdr;
  logic [63:0]         m_data;
  logic                m_rd, m_wr;
  int                  m_ptr;
  logic                m_vld;
  logic [8:0]          m_otid;
  logic [63:0]         m_odata;
  logic [NUM_SUB:0]    m_ovf;

  function automatic int route(input logic [15:0] a);
    logic [15:0] o;
    int s;
    if (a < BASE_ADDR) return -1;
    o = a - BASE_ADDR;
    s = int'(o) / (1 << SUB_ADDR_BITS);
    return (s < NUM_SUB) ? s : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    m_hdr = '0; m_data = '0; m_rd = 1'b0; m_wr = 1'b0;
    m_ptr = 0; m_vld = 1'b0; m_otid = '0; m_odata = '0; m_ovf = '0;
  endtask

  task automatic model_push(input int i, input logic [8:0] tid, input logic [63:0] data);
    rsp_t e;
    e.tid = tid;
    e.data = data;
    if (mq[i].size() < RSP_DEPTH) mq[i].push_back(e);
    else m_ovf[i] = 1'b1;
  endtask

  task automatic model_step();
    rsp_t e;
    int j;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (mq[j].size() > 0) begin
        e = mq[j].pop_front();
        m_vld = 1'b1;
        m_otid = e.tid;
        m_odata = e.data;
        m_ptr = (j + 1) % NREQ;
        break;
      end
    end
    for (int i = 0; i < NUM_SUB; i++)
      if (sub_tx[i].mmioRdValid) model_push(i, sub_tx[i].hdr.tid, sub_tx[i].data);
    if (m_rd && route(m_hdr.address) < 0) model_push(NUM_SUB, m_hdr.tid, DEFAULT_RDATA);
    m_hdr = in_hdr;
    m_data = in_data;
    m_rd = in_rdValid;
    m_wr = in_wrValid;
  endtask

  task automatic checkOutput();
    int r;
    r = route(m_hdr.address);
    cmp("out_valid", 64'(out_mmioRdValid), 64'(m_vld));
    cmp("out_tid", 64'(out_hdr.tid), 64'(m_otid));
    cmp("out_data", out_data, m_odata);
    cmp("err_overflow", 64'(err_overflow), 64'(m_ovf));
    for (int i = 0; i < NUM_SUB; i++) begin
      cmp($sformatf("sub%0d_rd", i), 64'(sub_rx[i].rdValid), 64'(m_rd && (r == i)));
      cmp($sformatf("sub%0d_wr", i), 64'(sub_rx[i].wrValid), 64'(m_wr && (r == i)));
      cmp($sformatf("sub%0d_hdr", i), 64'(sub_rx[i].hdr), 64'(m_hdr));
      cmp($sformatf("sub%0d_data", i), sub_rx[i].data, m_data);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [8:0] tid,
                               input logic [63:0] data, input logic rd, input logic wr);
    in_hdr = '0;
    in_hdr.address = addr;
    in_hdr.tid = tid;
    in_data = data;
    in_rdValid = rd;
    in_wrValid = wr;
  endtask

  task automatic set_rsp(input int i, input logic [8:0] tid, input logic [63:0] data);
    sub_tx[i].mmioRdValid = 1'b1;
    sub_tx[i].hdr.tid = tid;
    sub_tx[i].data = data;
  endtask

  task automatic idle();
    in_rdValid = 1'b0;
    in_wrValid = 1'b0;
    for (int i = 0; i < NUM_SUB; i++) sub_tx[i].mmioRdValid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [63:0] data;
    int          exp_sub;
  } vec_t;

  vec_t vt [10];
  logic [8:0] exp_tid;
  int got2;

  initial begin
    in_hdr = '0; in_data = '0; in_rdValid = 1'b0; in_wrValid = 1'b0;
    sub_tx = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput();
    cmp("reset_out_valid", 64'(out_mmioRdValid), 64'd0);
    cmp("reset_err_overflow", 64'(err_overflow), 64'd0);
    rst_n = 1'b1;

    vt[0] = '{16'h0405, 1'b0, 1'b1, 64'hDEAD_BEEF, 1};
    vt[1] = '{16'h0000, 1'b1, 1'b0, 64'h1, 0};
    vt[2] = '{16'h03FF, 1'b0, 1'b1, 64'h2, 0};
    vt[3] = '{16'h0400, 1'b1, 1'b0, 64'h3, 1};
    vt[4] = '{16'h0800, 1'b1, 1'b1, 64'h4, 2};
    vt[5] = '{16'h0C00, 1'b0, 1'b1, 64'h5, 3};
    vt[6] = '{16'h0FFF, 1'b1, 1'b0, 64'h6, 3};
    vt[7] = '{16'h1000, 1'b0, 1'b1, 64'h7, -1};
    vt[8] = '{16'hFFFF, 1'b1, 1'b0, 64'h8, -1};
    vt[9] = '{16'h1400, 1'b1, 1'b1, 64'h9, -1};
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vt[v].addr, 9'(v), vt[v].data, vt[v].rd, vt[v].wr);
      step();
      for (int i = 0; i < NUM_SUB; i++) begin
        cmp($sformatf("vec%0d_sub%0d_rd", v, i), 64'(sub_rx[i].rdValid),
            64'(vt[v].rd && vt[v].exp_sub == i));
        cmp($sformatf("vec%0d_sub%0d_wr", v, i), 64'(sub_rx[i].wrValid),
            64'(vt[v].wr && vt[v].exp_sub == i));
      end
      cmp($sformatf("vec%0d_addr", v), 64'(sub_rx[0].hdr.address), 64'(vt[v].addr));
      cmp($sformatf("vec%0d_data", v), sub_rx[NUM_SUB-1].data, vt[v].data);
    end
    idle();
    repeat (10) step();

    // Sub 0 answers a mapped read one cycle after seeing it.
    do_reset();
    applyStimulus(16'h0010, 9'h05, 64'h0, 1'b1, 1'b0);
    step();
    idle();
    cmp("rd_sub0_strobe", 64'(sub_rx[0].rdValid), 64'd1);
    step();
    set_rsp(0, 9'h05, 64'h1234);
    step();
    idle();
    cmp("rd_rsp_early", 64'(out_mmioRdValid), 64'd0);
    step();
    cmp("rd_rsp_valid", 64'(out_mmioRdValid), 64'd1);
    cmp("rd_rsp_tid", 64'(out_hdr.tid), 64'h05);
    cmp("rd_rsp_data", out_data, 64'h1234);

    // Unmapped read is answered by the internal responder at T+3.
    step();
    applyStimulus(16'h1000, 9'h1FF, 64'h0, 1'b1, 1'b0);
    step();
    idle();
    cmp("miss_no_strobe", 64'({sub_rx[3].rdValid, sub_rx[2].rdValid,
                                sub_rx[1].rdValid, sub_rx[0].rdValid}), 64'd0);
    step();
    cmp("miss_t2_idle", 64'(out_mmioRdValid), 64'd0);
    step();
    cmp("miss_valid", 64'(out_mmioRdValid), 64'd1);
    cmp("miss_tid", 64'(out_hdr.tid), 64'h1FF);
    cmp("miss_data", out_data, DEFAULT_RDATA);

    // All subs respond at once from pointer 0; then pointer sits on the
    // default responder, so it wins a tie against sub 0.
    do_reset();
    for (int i = 0; i < NUM_SUB; i++) set_rsp(i, 9'(i + 1), 64'(100 + i));
    step();
    idle();
    for (int k = 0; k < NUM_SUB; k++) begin
      step();
      cmp($sformatf("rr_valid%0d", k), 64'(out_mmioRdValid), 64'd1);
      cmp($sformatf("rr_tid%0d", k), 64'(out_hdr.tid), 64'(k + 1));
    end
    step();
    cmp("rr_done", 64'(out_mmioRdValid), 64'd0);
    applyStimulus(16'h2000, 9'h0AA, 64'h0, 1'b1, 1'b0);
    step();
    idle();
    set_rsp(0, 9'h0BB, 64'h55);
    step();
    idle();
    step();
    cmp("ptr4_first", 64'(out_hdr.tid), 64'h0AA);
    step();
    cmp("ptr4_second", 64'(out_hdr.tid), 64'h0BB);

    // Sub 2 bursts six responses while subs 0 and 1 compete.
    do_reset();
    got2 = 0;
    exp_tid = 9'h030;
    for (int c = 0; c < 36; c++) begin
      idle();
      if (c < 6) begin
        set_rsp(0, 9'(9'h010 + c), 64'(c));
        set_rsp(1, 9'(9'h020 + c), 64'(c));
        set_rsp(2, 9'(9'h030 + c), 64'(c));
      end
      step();
      if (out_mmioRdValid && out_hdr.tid[8:4] == 5'h03) begin
        cmp("ovf_order", 64'(out_hdr.tid), 64'(exp_tid));
        exp_tid = exp_tid + 9'd1;
        got2++;
      end
    end
    cmp("ovf_delivered", 64'(got2), 64'd5);
    cmp("ovf_sticky", 64'(err_overflow), 64'h04);
    do_reset();
    cmp("ovf_cleared", 64'(err_overflow), 64'd0);
    cmp("ovf_rst_tid", 64'(out_hdr.tid), 64'd0);
    cmp("ovf_rst_data", out_data, 64'd0);

    // Reset while responses are queued acts immediately and leaves nothing.
    set_rsp(0, 9'h041, 64'h1);
    set_rsp(1, 9'h042, 64'h2);
    set_rsp(3, 9'h043, 64'h3);
    step();
    idle();
    step();
    cmp("arst_pre_valid", 64'(out_mmioRdValid), 64'd1);
    rst_n = 1'b0;
    #1;
    cmp("arst_valid_drop", 64'(out_mmioRdValid), 64'd0);
    cmp("arst_tid_zero", 64'(out_hdr.tid), 64'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      cmp("arst_no_stale", 64'(out_mmioRdValid), 64'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      applyStimulus(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF)),
                    9'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      for (int i = 0; i < NUM_SUB; i++)
        if ($urandom_range(0, 3) == 0) set_rsp(i, 9'($urandom), {$urandom, $urandom});
      step();
    end
    idle();
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
